// File: rtl/sp3_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp3_align_ctrl
// Purpose  : Frame-alignment controller for the dual-channel SPROCKET3
//            receive path. Checks the lpGBT header in slot 0 of every frame
//            on channels A and B. It pulses the demux bitslip input of each
//            channel until that channel locks. On each 31->0 bitslip wrap it
//            also shifts the frame word phase, so every one of the
//            32*FRAME_WORDS bit positions is searched.
// Optional : SP3_ALIGN_STATS_EN adds the lock_loss_a/lock_loss_b counters.
// Ports    : mgtclk, reset (async, active-high)
//            enable              search enable
//            word_stb            one-cycle strobe, word_a/word_b valid
//            word_a, word_b      demux words, [1:0] received first
//            bitslip_a/_b        slip requests to the demux (2-cycle pulse)
//            locked_a/_b         channel locked
//            frame_start_a/_b    registered pulse after the slot-0 strobe
//            align_fail_a/_b     sticky, full sweep ended without lock
//            lock_loss_a/_b      (optional) saturating LOCKED->SEARCH count
// Revision : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
// One alignment channel. Only the two header bits of the word are needed.
// ---------------------------------------------------------------------------
module sp3_align_chan #(
  parameter int FRAME_WORDS = 4,
  parameter int GOOD_FRAMES = 8,
  parameter int BAD_FRAMES  = 4,
  parameter int SLIP_WAIT   = 48
) (
  input  logic       mgtclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       word_stb,
  input  logic [1:0] hdr,
  output logic       bitslip,
  output logic       locked,
  output logic       frame_start,
  output logic       align_fail
`ifdef SP3_ALIGN_STATS_EN
  ,
  output logic [15:0] lock_loss
`endif
);

  localparam logic [1:0] c_ST_SEARCH = 2'd0;
  localparam logic [1:0] c_ST_SLIP   = 2'd1;
  localparam logic [1:0] c_ST_WAIT   = 2'd2;
  localparam logic [1:0] c_ST_LOCKED = 2'd3;

  localparam int c_SLOT_W  = $clog2(FRAME_WORDS);
  localparam int c_SWEEP_W = $clog2(32 * FRAME_WORDS);
  localparam int c_WAIT_W  = $clog2(SLIP_WAIT);

  localparam logic [c_SWEEP_W-1:0] c_SWEEP_LAST = c_SWEEP_W'(32 * FRAME_WORDS - 1);
  localparam logic [c_WAIT_W-1:0]  c_WAIT_LAST  = c_WAIT_W'(SLIP_WAIT - 1);
  localparam logic [7:0]           c_GOOD_LAST  = 8'(GOOD_FRAMES - 1);
  localparam logic [7:0]           c_BAD_LAST   = 8'(BAD_FRAMES - 1);

  logic [1:0]           r_state;
  logic [c_SLOT_W-1:0]  r_slot;
  logic                 r_skip;
  logic                 r_slip_ph;
  logic [4:0]           r_slip_val;
  logic [c_SWEEP_W-1:0] r_sweep_cnt;
  logic [7:0]           r_good_cnt;
  logic [7:0]           r_bad_cnt;
  logic [c_WAIT_W-1:0]  r_wait_cnt;
  logic                 r_frame_start;
  logic                 r_align_fail;

  logic w_hdr_ok;
  logic w_eval;
  logic w_lock_lost;

  // 2'b01 and 2'b10 are the only valid lpGBT headers.
  assign w_hdr_ok = hdr[1] ^ hdr[0];
  assign w_eval   = word_stb & enable & (r_slot == '0);

  // Every way out of LOCKED lands in SEARCH, so this is the lock-loss event.
  assign w_lock_lost = (r_state == c_ST_LOCKED) &
                       (~enable | (w_eval & ~w_hdr_ok & (r_bad_cnt == c_BAD_LAST)));

  always_ff @(posedge mgtclk or posedge reset) begin
    if (reset) begin
      r_state       <= c_ST_SEARCH;
      r_slot        <= '0;
      r_skip        <= 1'b0;
      r_slip_ph     <= 1'b0;
      r_slip_val    <= 5'd0;
      r_sweep_cnt   <= '0;
      r_good_cnt    <= 8'd0;
      r_bad_cnt     <= 8'd0;
      r_wait_cnt    <= '0;
      r_frame_start <= 1'b0;
      r_align_fail  <= 1'b0;
    end else begin
      r_frame_start <= word_stb & (r_slot == '0);

      // A pending phase skip swallows one slot increment. This slides the
      // slot-0 position one word later in the stream.
      if (word_stb) begin
        if (r_skip) begin
          r_skip <= 1'b0;
        end else begin
          r_slot <= r_slot + 1'b1;
        end
      end

      case (r_state)
        c_ST_SEARCH: begin
          if (!enable) begin
            r_good_cnt  <= 8'd0;
            r_bad_cnt   <= 8'd0;
            r_sweep_cnt <= '0;
          end else if (w_eval) begin
            if (w_hdr_ok) begin
              if (r_good_cnt == c_GOOD_LAST) begin
                r_state     <= c_ST_LOCKED;
                r_good_cnt  <= 8'd0;
                r_sweep_cnt <= '0;
              end else begin
                r_good_cnt <= r_good_cnt + 8'd1;
              end
            end else begin
              r_good_cnt <= 8'd0;
              r_state    <= c_ST_SLIP;
              r_slip_ph  <= 1'b0;
              r_slip_val <= r_slip_val + 5'd1;
              // This assignment overrides the skip clear above. It is safe
              // because a skip is always used up long before the next slip.
              if (r_slip_val == 5'd31) begin
                r_skip <= 1'b1;
              end
              if (r_sweep_cnt == c_SWEEP_LAST) begin
                r_align_fail <= 1'b1;
                r_sweep_cnt  <= '0;
              end else begin
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
              end
            end
          end
        end

        // Two cycles in SLIP keep bitslip high long enough for exactly one
        // mgtclk_div2 edge in the demux to see it, whatever its phase.
        c_ST_SLIP: begin
          if (r_slip_ph) begin
            r_state    <= c_ST_WAIT;
            r_wait_cnt <= '0;
          end else begin
            r_slip_ph <= 1'b1;
          end
        end

        c_ST_WAIT: begin
          if (!enable) begin
            r_state     <= c_ST_SEARCH;
            r_good_cnt  <= 8'd0;
            r_bad_cnt   <= 8'd0;
            r_sweep_cnt <= '0;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_state <= c_ST_SEARCH;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        default: begin // c_ST_LOCKED
          if (!enable) begin
            r_state     <= c_ST_SEARCH;
            r_good_cnt  <= 8'd0;
            r_bad_cnt   <= 8'd0;
            r_sweep_cnt <= '0;
          end else if (w_eval) begin
            if (w_hdr_ok) begin
              r_bad_cnt <= 8'd0;
            end else if (r_bad_cnt == c_BAD_LAST) begin
              r_state    <= c_ST_SEARCH;
              r_bad_cnt  <= 8'd0;
              r_good_cnt <= 8'd0;
            end else begin
              r_bad_cnt <= r_bad_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end

  // Taken straight from the state register, so reset drops bitslip at once.
  assign bitslip     = (r_state == c_ST_SLIP);
  assign locked      = (r_state == c_ST_LOCKED);
  assign frame_start = r_frame_start;
  assign align_fail  = r_align_fail;

`ifdef SP3_ALIGN_STATS_EN
  logic [15:0] r_lock_loss;

  always_ff @(posedge mgtclk or posedge reset) begin
    if (reset) begin
      r_lock_loss <= 16'd0;
    end else if (w_lock_lost && (r_lock_loss != 16'hFFFF)) begin
      r_lock_loss <= r_lock_loss + 16'd1;
    end
  end

  assign lock_loss = r_lock_loss;
`else
  logic w_unused_lost;
  assign w_unused_lost = w_lock_lost;
`endif

endmodule

// ---------------------------------------------------------------------------
// Top: two independent channels that share clock, reset, enable and strobe.
// ---------------------------------------------------------------------------
module sp3_align_ctrl #(
  parameter int FRAME_WORDS = 4,
  parameter int GOOD_FRAMES = 8,
  parameter int BAD_FRAMES  = 4,
  parameter int SLIP_WAIT   = 48
) (
  input  logic        mgtclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        word_stb,
  input  logic [31:0] word_a,
  input  logic [31:0] word_b,
  output logic        bitslip_a,
  output logic        bitslip_b,
  output logic        locked_a,
  output logic        locked_b,
  output logic        frame_start_a,
  output logic        frame_start_b,
  output logic        align_fail_a,
  output logic        align_fail_b
`ifdef SP3_ALIGN_STATS_EN
  ,
  output logic [15:0] lock_loss_a,
  output logic [15:0] lock_loss_b
`endif
);

  // Only the header bits matter here. The payload goes to the decoders.
  logic w_unused_payload;
  assign w_unused_payload = ^{word_a[31:2], word_b[31:2]};

  sp3_align_chan #(
    .FRAME_WORDS (FRAME_WORDS),
    .GOOD_FRAMES (GOOD_FRAMES),
    .BAD_FRAMES  (BAD_FRAMES),
    .SLIP_WAIT   (SLIP_WAIT)
  ) u_chan_a (
    .mgtclk      (mgtclk),
    .reset       (reset),
    .enable      (enable),
    .word_stb    (word_stb),
    .hdr         (word_a[1:0]),
    .bitslip     (bitslip_a),
    .locked      (locked_a),
    .frame_start (frame_start_a),
    .align_fail  (align_fail_a)
`ifdef SP3_ALIGN_STATS_EN
    ,
    .lock_loss   (lock_loss_a)
`endif
  );

  sp3_align_chan #(
    .FRAME_WORDS (FRAME_WORDS),
    .GOOD_FRAMES (GOOD_FRAMES),
    .BAD_FRAMES  (BAD_FRAMES),
    .SLIP_WAIT   (SLIP_WAIT)
  ) u_chan_b (
    .mgtclk      (mgtclk),
    .reset       (reset),
    .enable      (enable),
    .word_stb    (word_stb),
    .hdr         (word_b[1:0]),
    .bitslip     (bitslip_b),
    .locked      (locked_b),
    .frame_start (frame_start_b),
    .align_fail  (align_fail_b)
`ifdef SP3_ALIGN_STATS_EN
    ,
    .lock_loss   (lock_loss_b)
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_sp3_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp3_align_ctrl
// Purpose  : Directed self-checking bench for sp3_align_ctrl (FRAME_WORDS=4,
//            GOOD_FRAMES=8, BAD_FRAMES=4, SLIP_WAIT=48). A simple stream
//            source models the demux. Each bitslip pulse removes one bit of
//            misalignment (mod 32). A channel has a good header only when
//            the bit offset is zero and the word is the true frame word.
// Optional : SP3_ALIGN_STATS_EN also checks lock_loss_a/lock_loss_b.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp3_align_ctrl;

  localparam int c_FW = 4;

  logic        mgtclk = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        word_stb = 1'b0;
  logic [31:0] word_a = 32'd0;
  logic [31:0] word_b = 32'd0;
  logic        bitslip_a, bitslip_b, locked_a, locked_b;
  logic        frame_start_a, frame_start_b, align_fail_a, align_fail_b;
`ifdef SP3_ALIGN_STATS_EN
  logic [15:0] lock_loss_a, lock_loss_b;
`endif

  sp3_align_ctrl #(
    .FRAME_WORDS (c_FW),
    .GOOD_FRAMES (8),
    .BAD_FRAMES  (4),
    .SLIP_WAIT   (48)
  ) u_dut (
    .mgtclk        (mgtclk),
    .reset         (reset),
    .enable        (enable),
    .word_stb      (word_stb),
    .word_a        (word_a),
    .word_b        (word_b),
    .bitslip_a     (bitslip_a),
    .bitslip_b     (bitslip_b),
    .locked_a      (locked_a),
    .locked_b      (locked_b),
    .frame_start_a (frame_start_a),
    .frame_start_b (frame_start_b),
    .align_fail_a  (align_fail_a),
    .align_fail_b  (align_fail_b)
`ifdef SP3_ALIGN_STATS_EN
    ,
    .lock_loss_a   (lock_loss_a),
    .lock_loss_b   (lock_loss_b)
`endif
  );

  initial forever #5 mgtclk = ~mgtclk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Stream-model state
  int m[2];          // remaining bit misalignment per channel
  int woff[2];       // true frame-header word index per channel
  int slips[2];      // bitslip pulses seen per channel
  bit allbad_a;      // channel A sends no valid header at all
  int bad_hdrs_a;    // force the next N true headers of A to be bad
  int bad_seq_a;     // forced-bad headers emitted in this burst
  int cyc4_a;        // cycle in which the 4th forced-bad header was strobed
  int af_slips_a;    // slip count when align_fail_a rose

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge mgtclk);
    cyc++;
  end

  // Stream source: a strobe every second cycle, driven 1 time unit after the edge.
  initial begin : g_stream
    bit phase;
    int tslot;
    logic [31:0] w;
    phase = 1'b0;
    tslot = 0;
    forever begin
      @(posedge mgtclk);
      #1;
      if (reset) begin
        phase    = 1'b0;
        tslot    = 0;
        word_stb = 1'b0;
      end else begin
        phase = ~phase;
        if (phase) begin
          word_stb = 1'b1;
          w = $urandom();
          if (tslot == woff[0] && m[0] == 0 && !allbad_a) begin
            if (bad_hdrs_a > 0) begin
              bad_hdrs_a--;
              bad_seq_a++;
              if (bad_seq_a == 4) cyc4_a = cyc;
              w[1:0] = 2'b11;
            end else begin
              w[1:0] = 2'b10;
            end
          end else begin
            w[1:0] = (tslot % 2 == 1) ? 2'b00 : 2'b11;
          end
          word_a = w;
          w = $urandom();
          if (tslot == woff[1] && m[1] == 0) w[1:0] = 2'b01;
          else                               w[1:0] = 2'b11;
          word_b = w;
          tslot = (tslot + 1) % c_FW;
        end else begin
          word_stb = 1'b0;
        end
      end
    end
  end

  // Slip monitor: checks pulse width and spacing, and applies each slip to
  // the stream model.
  initial begin : g_slip_mon
    bit prev[2];
    bit have_fall[2];
    int width[2];
    int last_fall[2];
    bit prev_af;
    bit cur;
    prev = '{0, 0};
    have_fall = '{0, 0};
    width = '{0, 0};
    last_fall = '{0, 0};
    prev_af = 1'b0;
    forever begin
      @(negedge mgtclk);
      if (reset) begin
        prev = '{0, 0};
        have_fall = '{0, 0};
        width = '{0, 0};
        prev_af = 1'b0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          cur = (c == 0) ? bitslip_a : bitslip_b;
          if (cur && !prev[c]) begin
            slips[c]++;
            if (have_fall[c]) chk_vec("slip_gap_ge48", 32'((cyc - last_fall[c]) >= 48), 1);
            width[c] = 1;
            m[c] = (m[c] + 31) % 32;
          end else if (cur) begin
            width[c]++;
          end else if (prev[c]) begin
            chk_vec("slip_width", width[c], 2);
            last_fall[c] = cyc;
            have_fall[c] = 1'b1;
          end
          prev[c] = cur;
        end
        if (align_fail_a && !prev_af) af_slips_a = slips[0];
        prev_af = align_fail_a;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start_test(input int bits_a, input int words_a, input bit allbad, input bit en);
    @(negedge mgtclk);
    reset      = 1'b1;
    m[0]       = bits_a;
    woff[0]    = words_a;
    m[1]       = 0;
    woff[1]    = 0;
    allbad_a   = allbad;
    bad_hdrs_a = 0;
    bad_seq_a  = 0;
    cyc4_a     = 0;
    af_slips_a = 0;
    slips[0]   = 0;
    slips[1]   = 0;
    enable     = en;
    repeat (3) @(negedge mgtclk);
    chk_vec("reset_outputs",
            {24'd0, bitslip_a, bitslip_b, locked_a, locked_b,
             frame_start_a, frame_start_b, align_fail_a, align_fail_b}, 0);
`ifdef SP3_ALIGN_STATS_EN
    chk_vec("reset_lock_loss", {lock_loss_a, lock_loss_b}, 0);
`endif
    reset = 1'b0;
  endtask

  task automatic wait_locked_a(input int budget);
    for (int i = 0; i < budget && !locked_a; i++) @(negedge mgtclk);
  endtask

  initial begin
    int n;
    int s0;
    bit stayed;

    // 1: aligned stream, both channels lock on the 8th slot-0 strobe.
    start_test(0, 0, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge mgtclk);
      if (frame_start_a) n++;
      if (locked_a) break;
    end
    chk_vec("t1_locked_a", locked_a, 1);
    chk_vec("t1_locked_b", locked_b, 1);
    chk_vec("t1_frames_to_lock", n, 8);
    n = 0;
    repeat (64) begin
      @(negedge mgtclk);
      if (frame_start_b) n++;
    end
    chk_vec("t1_frame_start_rate", n, 8);
    chk_vec("t1_no_slips", slips[0] + slips[1], 0);
`ifdef SP3_ALIGN_STATS_EN
    chk_vec("t1_lock_loss_a", lock_loss_a, 0);
`endif

    // 2: A is 5 bits off.
    start_test(5, 0, 1'b0, 1'b1);
    wait_locked_a(3000);
    chk_vec("t2_locked_a", locked_a, 1);
    chk_vec("t2_slips_a", slips[0], 5);
    chk_vec("t2_locked_b", locked_b, 1);
    chk_vec("t2_slips_b", slips[1], 0);

    // 3: A is 1 word + 3 bits off, so a phase skip is needed.
    start_test(3, 1, 1'b0, 1'b1);
    wait_locked_a(5000);
    chk_vec("t3_locked_a", locked_a, 1);
    chk_vec("t3_slips_a", slips[0], 35);

    // 4: bad-header tolerance while locked.
    start_test(0, 0, 1'b0, 1'b1);
    wait_locked_a(200);
    chk_vec("t4_locked_a", locked_a, 1);
    bad_hdrs_a = 3;
    stayed = 1'b1;
    repeat (120) begin
      @(negedge mgtclk);
      if (!locked_a) stayed = 1'b0;
    end
    chk_vec("t4_hold_after_3_bad", stayed, 1);
    bad_seq_a  = 0;
    bad_hdrs_a = 5;
    s0 = slips[0];
    for (int i = 0; i < 200 && locked_a; i++) @(negedge mgtclk);
    chk_vec("t4_lock_dropped", locked_a, 0);
    chk_vec("t4_drop_latency", cyc - cyc4_a, 1);
    for (int i = 0; i < 200 && slips[0] == s0; i++) @(negedge mgtclk);
    chk_vec("t4_slip_resumed", slips[0] - s0, 1);
    chk_vec("t4_locked_b", locked_b, 1);
`ifdef SP3_ALIGN_STATS_EN
    chk_vec("t4_lock_loss_a", lock_loss_a, 1);
    chk_vec("t4_lock_loss_b", lock_loss_b, 0);
`endif

    // 5: no valid header ever on A, so a full sweep fails.
    start_test(0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 10000 && !align_fail_a; i++) @(negedge mgtclk);
    @(negedge mgtclk);
    chk_vec("t5_align_fail_a", align_fail_a, 1);
    chk_vec("t5_slips_at_fail", af_slips_a, 128);
    for (int i = 0; i < 200 && slips[0] < 129; i++) @(negedge mgtclk);
    chk_vec("t5_slipping_continues", 32'(slips[0] >= 129), 1);
    chk_vec("t5_align_fail_b", align_fail_b, 0);
    for (int i = 0; i < 200 && !bitslip_a; i++) @(negedge mgtclk);
    chk_vec("t5_pulse_seen", bitslip_a, 1);
    reset = 1'b1;
    #1;
    chk_vec("t5_async_bitslip_drop", bitslip_a, 0);
    chk_vec("t5_align_fail_cleared", align_fail_a, 0);

    // 6: enable dropped during the first cycle of a pulse.
    start_test(5, 0, 1'b0, 1'b1);
    for (int i = 0; i < 100 && !bitslip_a; i++) @(negedge mgtclk);
    chk_vec("t6_pulse_seen", bitslip_a, 1);
    enable = 1'b0;
    repeat (300) @(negedge mgtclk);
    chk_vec("t6_single_slip", slips[0], 1);
    chk_vec("t6_idle_outputs", {29'd0, bitslip_a, locked_a, locked_b}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
